// File: rtl/v850_gr_file.sv
// V850 general-register file: NUM_RD registered read ports, execute (A) and load (B) writeback, load scoreboard.
// Optional same-cycle write-to-read bypass is compiled in with `define V850_GR_BYPASS_EN.
module v850_gr_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wa_en_i,
  input  logic [ADDR_W-1:0]        wa_addr_i,
  input  logic [DATA_W-1:0]        wa_data_i,
  input  logic                     wb_en_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic                     res_en_i,
  input  logic [ADDR_W-1:0]        res_addr_i,
  output logic                     stall_o,
  output logic [ADDR_W:0]          busy_cnt_o,
  output logic                     collide_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]        gr_q [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [ADDR_W:0]          busy_cnt_q, busy_cnt_d;
  logic                     collide_q, collide_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic [ADDR_W-1:0]        rd_addr [NUM_RD];
  logic                     wa_we, wb_we;
  logic                     stall;

  // B has priority on a shared address, so A is suppressed there.
  always_comb begin
    wb_we     = wb_en_i && (wb_addr_i != '0);
    wa_we     = wa_en_i && (wa_addr_i != '0) && !(wb_we && (wb_addr_i == wa_addr_i));
    collide_d = wa_en_i && wb_we && (wa_addr_i == wb_addr_i);
  end

  // Clear first, then set, so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i) busy_d[wb_addr_i] = 1'b0;
    if (res_en_i) busy_d[res_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    stall     = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
`ifdef V850_GR_BYPASS_EN
      // A cleared-and-not-rereserved register no longer stalls.
      if (rd_en_i[k] && (rd_addr[k] != '0) && busy_q[rd_addr[k]] && busy_d[rd_addr[k]]) stall = 1'b1;
`else
      if (rd_en_i[k] && (rd_addr[k] != '0) && busy_q[rd_addr[k]]) stall = 1'b1;
`endif
      if (rd_en_i[k]) begin
        if (rd_addr[k] == '0) begin
          rd_data_d[k*DATA_W +: DATA_W] = '0;
          rd_busy_d[k]                  = 1'b0;
        end else begin
`ifdef V850_GR_BYPASS_EN
          if (wb_we && (wb_addr_i == rd_addr[k])) begin
            rd_data_d[k*DATA_W +: DATA_W] = wb_data_i;
          end else if (wa_we && (wa_addr_i == rd_addr[k])) begin
            rd_data_d[k*DATA_W +: DATA_W] = wa_data_i;
          end else begin
            rd_data_d[k*DATA_W +: DATA_W] = gr_q[rd_addr[k]];
          end
          rd_busy_d[k] = busy_d[rd_addr[k]];
`else
          rd_data_d[k*DATA_W +: DATA_W] = gr_q[rd_addr[k]];
          rd_busy_d[k]                  = busy_q[rd_addr[k]];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) gr_q[i] <= '0;
    end else begin
      if (wa_we) gr_q[wa_addr_i] <= wa_data_i;
      if (wb_we) gr_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      collide_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      collide_q  <= collide_d;
      rd_data_q  <= rd_data_d;
      rd_busy_q  <= rd_busy_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_busy_o  = rd_busy_q;
  assign busy_cnt_o = busy_cnt_q;
  assign collide_o  = collide_q;
  assign stall_o    = stall;

endmodule

// File: doc/v850_gr_file.md
# v850_gr_file

Parametrised general-register file for the V850 core, the next generation of the plain `GR[31:0]` array shared by the decoder and executer. It provides NUM_RD synchronous read ports and two write ports: execute writeback (A) and load writeback (B). It also has a load scoreboard that marks destination registers busy from issue until load writeback, so the decoder can stall on RAW hazards. r0 is hardwired to zero.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, read port count (1..4)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en_i  in  NUM_RD  per-port read enable
- rd_addr_i  in  NUM_RD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  registered read data
- rd_busy_o  out  NUM_RD  registered busy flag of the register read
- wa_en_i / wa_addr_i / wa_data_i  in  1 / ADDR_W / DATA_W  execute writeback port A
- wb_en_i / wb_addr_i / wb_data_i  in  1 / ADDR_W / DATA_W  load writeback port B; clears busy
- res_en_i / res_addr_i  in  1 / ADDR_W  load issue; sets busy on res_addr_i
- stall_o  out  1  combinational: some enabled rd_addr_i is currently busy
- busy_cnt_o  out  ADDR_W+1  number of busy registers
- collide_o  out  1  registered one-cycle pulse: A and B wrote the same nonzero address in one cycle

## Operation
- Storage: NUM_REGS x DATA_W flops. A scoreboard holds one busy bit per register.
- Reads: when rd_en_i[k]=1, rd_data_o[k] and rd_busy_o[k] load on the next edge. When rd_en_i[k]=0, both hold their value.
- Reads of r0 always return 0 with busy 0.
- Writes: a write to r0 is ignored on either port.
  - A and B target the same address in one cycle: B wins and collide_o pulses.
  - A and B target different addresses: both are written.
- Scoreboard, evaluated per edge:
  - res_en_i with a nonzero address sets busy.
  - wb_en_i clears busy on wb_addr_i.
  - Reserve and clear on the same address in one cycle: reserve wins and busy stays 1.
  - Reserving an already-busy register leaves it busy and busy_cnt_o unchanged.
  - A port-A write does not affect busy.
- busy_cnt_o is the population count of the busy bits, registered and consistent with the bits after the same edge.
- stall_o = OR over k of (rd_en_i[k] & busy[rd_addr_i[k]] & rd_addr_i[k]!=0). It uses the pre-edge scoreboard; see the configuration option for bypass of a same-cycle clear.

## Timing
- Reset (async assert, sync release) sets:
  - all GR and busy bits to 0
  - rd_data_o=0, rd_busy_o=0, busy_cnt_o=0, collide_o=0
  - stall_o=0 by construction, since the scoreboard is clear
- Read latency is 1 cycle. Write latency is 1 cycle, so the value is visible to a read issued in the next cycle.
- A read of the address being written in the same cycle returns old data unless bypass is compiled in.
- Reset asserted mid-operation discards all pending reservations. No load writeback is expected after reset; a late one writes data and leaves busy cleared.
- There is no backpressure. The file accepts every request every cycle.

## Configuration
- V850_GR_BYPASS_EN defined:
  - A read of an address being written in the same cycle returns the write data, with B priority over A.
  - A port-B write on that address also returns rd_busy_o=0 and removes that register from stall_o in the same cycle.
  - A same-cycle reserve of that address still yields busy=1.
- Undefined: a read returns pre-write data and pre-edge busy, and stall_o uses the pre-edge scoreboard only.

## Test plan
- Reset, then read r0..r31 on both ports -> all data 0, busy 0, busy_cnt_o=0.
- Write A r3=0x1234_5678, then read r3 next cycle -> rd_data_o=0x1234_5678. Write A r0=0xFFFF_FFFF, then read r0 -> 0.
- Reserve r7, then read r7 -> stall_o=1 that cycle, rd_busy_o=1, busy_cnt_o=1.
  - Then B writes r7=0xCAFE -> busy_cnt_o=0.
  - Read r7 -> 0xCAFE, busy 0.
- Same cycle: A writes r5=1 and B writes r5=2 -> r5 reads 2 and collide_o pulses once. Same-cycle A r5 with B r6 -> no pulse.
- r9 busy, then in one cycle B-write r9 and reserve r9 -> r9 stays busy and busy_cnt_o is unchanged.
- Same-cycle read and B-write of r4=0xBEEF:
  - With V850_GR_BYPASS_EN -> data 0xBEEF, busy 0.
  - Without -> old value, and the next read returns 0xBEEF.
